controlador_acesso_memoria: RTL
===============================

# controlador_acesso_memoria

Load/store access controller that sits between the processor datapath and a word-wide, byte-enabled data memory. It accepts one byte, halfword or word load/store request per handshake at any byte address. It splits accesses that cross a word boundary into two aligned word transactions and rotates write data into byte lanes. For loads it merges and rotates the returned bytes, then zero- or sign-extends the result.

## Interface
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
- ADDR_WIDTH, 14, byte address width; word address is ADDR_WIDTH-2 bits

- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  request strobe; accepted only when ready=1
- ready  out  1  controller idle, able to accept req
- EscMen  in  1  sampled on accept: 1 = store, 0 = load
- DataType  in  2  sampled on accept: 01 byte, 10 halfword, 00/11 word
- Signed  in  1  sampled on accept: 1 = sign-extend load result
- addr  in  ADDR_WIDTH  byte address, sampled on accept
- wdata  in  32  store data, sampled on accept; valid bytes are the low n bytes
- rdata  out  32  load result, updated in the done cycle, held until the next load completes
- done  out  1  one-cycle completion pulse (loads and stores)
- mem_addr  out  ADDR_WIDTH-2  word address
- mem_wdata  out  32  lane-rotated write data
- mem_be  out  4  byte-lane enables; lane k = byte address 4w+k (little-endian)
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  32  read data, valid the cycle after mem_re

## Operation
- Size n = 1/2/4 bytes from DataType. Offset o = addr[1:0]. split = (o+n > 4).
- States:
  - IDLE: ready=1. On req: latch op, n, o, Signed, addr, wdata; go to FIRST.
  - FIRST: issue word w0 = addr[ADDR_WIDTH-1:2]. If split, go to SECOND; else go to FINISH.
  - SECOND: issue word w1 = w0+1, modulo 2^(ADDR_WIDTH-2) (wraps to 0). Capture the FIRST read data. Go to FINISH.
  - FINISH: for loads, capture the last read data and form rdata. Pulse done. Go to IDLE.
- Byte-enable mask: m = ((1<<n)-1) << o, 8 bits wide. FIRST uses mem_be = m[3:0]; SECOND uses mem_be = m[7:4].
- Write data: mem_wdata = wdata rotated left by 8*o in both FIRST and SECOND, so byte i lands in lane (o+i) mod 4.
- Strobes: store drives mem_we=1, mem_re=0; load drives mem_re=1, mem_we=0.
- In IDLE and FINISH, all memory outputs are 0.
- Load merge: lane k comes from the FIRST word if m[k]=1, else from the SECOND word. Rotate the merged word right by 8*o, keep the low n bytes, and fill the upper bytes with 0, or with bit 8n-1 when Signed=1.
- Word accesses ignore Signed.
- Stores never modify rdata.
- req while ready=0 is ignored (not queued).

## Timing
- Reset values: state IDLE, ready=1, done=0, rdata=0, mem_we=0, mem_re=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Accept in cycle t (req=1, ready=1).
  - Non-split: FIRST in t+1, done in t+2, ready=1 again in t+3.
  - Split: FIRST in t+1, SECOND in t+2, done in t+3, ready=1 in t+4.
- Exactly one memory strobe cycle per transaction; never more than two per request.
- Reset takes priority over all other inputs in any state.
  - Reset mid-operation: next cycle is IDLE with reset values.
  - No further strobes and no done pulse for the aborted request.
- A req in the same cycle as reset is discarded.

## Test plan
- Aligned word store, addr 0x0010, wdata 0xDEADBEEF:
  - One strobe with mem_addr=0x004, be=1111, wdata 0xDEADBEEF, we=1.
  - done at t+2.
- Byte load, addr 0x0013, memory word 0x004 = 0x80123456:
  - Signed=1 gives rdata 0xFFFFFF80; Signed=0 gives 0x00000080.
  - done at t+2.
- Misaligned word store, addr 0x0006, wdata 0x11223344:
  - Strobe 1: mem_addr 0x001, be=1100. Strobe 2: mem_addr 0x002, be=0011.
  - Both strobes carry mem_wdata 0x33441122.
  - done at t+3.
- Misaligned halfword load, addr 0x0007, word1 lane3=0xAB, word2 lane0=0xCD:
  - Signed=0 gives 0x0000CDAB; Signed=1 gives 0xFFFFCDAB.
- Wrap-around word load, addr 0x3FFF:
  - Strobe 1: mem_addr 0xFFF, be=1000. Strobe 2: mem_addr 0x000, be=0111.
  - Words 0xAA000000 and 0x00DDCCBB give rdata 0xDDCCBBAA.
- Reset and busy handling:
  - Reset in SECOND of a split load: next cycle ready=1, all strobes 0, done never pulses, rdata=0.
  - req held high during a busy request: accepted only once ready=1.

Source files
------------

// File: rtl/controlador_acesso_memoria.sv
// Load/store access controller between the datapath and a 32-bit byte-enabled data memory.
// Splits word-crossing accesses into two aligned transactions, rotates lanes, and extends loads.
module controlador_acesso_memoria #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    output logic                  ready,
    input  logic                  EscMen,
    input  logic [1:0]            DataType,
    input  logic                  Signed,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            fsm_state
);

    // Handshake: a request transfers on a rising edge where req=1 and ready=1; req while
    // ready=0 is dropped. done is a single-cycle pulse, and rdata is valid while done=1.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state, state_next;

    logic                  op_store;
    logic                  op_signed;
    logic [2:0]            op_size;
    logic [1:0]            op_off;
    logic [ADDR_WIDTH-3:0] op_word;
    logic [31:0]           op_wdata;
    logic [31:0]           first_data;
    logic [31:0]           rdata_q;

    logic [2:0]  req_size;
    logic [7:0]  size_mask;
    logic [7:0]  mask;
    logic        split;
    logic [63:0] wdata_dbl;
    logic [31:0] wdata_rot;
    logic [31:0] first_word;
    logic [31:0] merged;
    logic [63:0] merged_dbl;
    logic [31:0] shifted;
    logic [31:0] load_word;

    always_comb begin
        case (DataType)
            2'b01:   req_size = 3'd1;
            2'b10:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            op_store   <= 1'b0;
            op_signed  <= 1'b0;
            op_size    <= 3'd4;
            op_off     <= 2'd0;
            op_word    <= '0;
            op_wdata   <= '0;
            first_data <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req) begin
                op_store  <= EscMen;
                op_signed <= Signed;
                op_size   <= req_size;
                op_off    <= addr[1:0];
                op_word   <= addr[ADDR_WIDTH-1:2];
                op_wdata  <= wdata;
            end
            if (state == SECOND) begin
                first_data <= mem_rdata;
            end
            if (state == FINISH && !op_store) begin
                rdata_q <= load_word;
            end
        end
    end

    // Lanes above 3 in the shifted mask belong to the following word.
    always_comb begin
        case (op_size)
            3'd1:    size_mask = 8'h01;
            3'd2:    size_mask = 8'h03;
            default: size_mask = 8'h0F;
        endcase
        mask  = size_mask << op_off;
        split = |mask[7:4];
    end

    always_comb begin
        wdata_dbl = {op_wdata, op_wdata} << {op_off, 3'b000};
        wdata_rot = wdata_dbl[63:32];
    end

    // Without a split, every enabled lane comes from the single read word now on mem_rdata.
    always_comb begin
        first_word = split ? first_data : mem_rdata;
        merged     = '0;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = mask[k] ? first_word[8*k +: 8] : mem_rdata[8*k +: 8];
        end
        merged_dbl = {merged, merged} >> {op_off, 3'b000};
        shifted    = merged_dbl[31:0];
        case (op_size)
            3'd1:    load_word = {{24{op_signed & shifted[7]}}, shifted[7:0]};
            3'd2:    load_word = {{16{op_signed & shifted[15]}}, shifted[15:0]};
            default: load_word = shifted;
        endcase
    end

    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = 4'b0000;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_next = FIRST;
            end
            FIRST: begin
                mem_addr   = op_word;
                mem_be     = mask[3:0];
                mem_wdata  = wdata_rot;
                mem_we     = op_store;
                mem_re     = !op_store;
                state_next = split ? SECOND : FINISH;
            end
            SECOND: begin
                mem_addr   = op_word + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
                mem_be     = mask[7:4];
                mem_wdata  = wdata_rot;
                mem_we     = op_store;
                mem_re     = !op_store;
                state_next = FINISH;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready     = (state == IDLE);
    assign done      = (state == FINISH);
    assign rdata     = (state == FINISH && !op_store) ? load_word : rdata_q;
    assign fsm_state = state;

endmodule
